// File: rtl/credit_manager.sv
// rtl/credit_manager.sv - coin credit accumulator with vend/refund arbitration and change payout
//
// Purpose: accumulates committed coin pulse counts into credit units, grants or
// denies vends, holds a timed dispense strobe and pays change to a hopper as
// timed pulses. Optional idle auto-refund is enabled by defining CREDIT_TIMEOUT_EN.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   coin_in       committed pulse count, nonzero one cycle per coin
//   vend_req      vend request (IDLE only), price sampled with it
//   price         item price in credit units
//   refund_req    refund request (IDLE only)
//   credit        current credit (registered)
//   dispense      item-release strobe
//   change_pulse  hopper drive, one high phase per CHANGE_UNIT paid
//   busy          high whenever not IDLE
//   deny          one-cycle pulse on vend refused for insufficient credit
//   coin_overflow one-cycle pulse when credit saturates

module credit_manager #(
  parameter int COIN_WIDTH          = 6,
  parameter int CREDIT_WIDTH        = 12,
  parameter int MAX_CREDIT          = 4000,
  parameter int UNIT_VALUE          = 10,
  parameter int DISPENSE_CYCLES     = 100,
  parameter int CHANGE_UNIT         = 50,
  parameter int CHANGE_PULSE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES      = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COIN_WIDTH-1:0]   coin_in,
  input  logic                    vend_req,
  input  logic [CREDIT_WIDTH-1:0] price,
  input  logic                    refund_req,
  output logic [CREDIT_WIDTH-1:0] credit,
  output logic                    dispense,
  output logic                    change_pulse,
  output logic                    busy,
  output logic                    deny,
  output logic                    coin_overflow
);

  // Wide enough that credit + the largest coin never wraps before saturation.
  localparam int NW      = CREDIT_WIDTH + COIN_WIDTH + 4;
  localparam int CNT_MAX = (DISPENSE_CYCLES > CHANGE_PULSE_CYCLES) ? DISPENSE_CYCLES : CHANGE_PULSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]           DISP_LAST = CW'(DISPENSE_CYCLES - 1);
  localparam logic [CW-1:0]           CHG_LAST  = CW'(CHANGE_PULSE_CYCLES - 1);
  localparam logic [CREDIT_WIDTH-1:0] CU_C      = CREDIT_WIDTH'(CHANGE_UNIT);

  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE_HI, CHANGE_LO} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    take_price, take_change, deny_n, timeout_hit;
  logic [NW-1:0]           add_w, sub_w, next_w;
  logic                    sat;
  logic [CREDIT_WIDTH-1:0] credit_n;

`ifdef CREDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES));

  // Counts only undisturbed IDLE cycles with credit held; any activity restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != IDLE || coin_in != '0 || vend_req || refund_req ||
                 credit == '0 || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and deduction selection.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    take_price  = 1'b0;
    take_change = 1'b0;
    deny_n      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (vend_req) begin
          if (credit >= price) begin
            take_price = 1'b1;
            state_n    = DISPENSE;
          end else begin
            deny_n = 1'b1;
          end
        end else if ((refund_req || timeout_hit) && credit >= CU_C) begin
          state_n = CHANGE_HI;
        end
      end
      DISPENSE: begin
        if (cnt == DISP_LAST) begin
          cnt_n   = '0;
          state_n = (credit >= CU_C) ? CHANGE_HI : IDLE;
        end
      end
      CHANGE_HI: begin
        if (cnt == CHG_LAST) begin
          cnt_n       = '0;
          take_change = 1'b1;
          state_n     = CHANGE_LO;
        end
      end
      CHANGE_LO: begin
        // Re-evaluated here so coins added during payout extend it.
        if (cnt == CHG_LAST) begin
          cnt_n   = '0;
          state_n = (credit >= CU_C) ? CHANGE_HI : IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Credit datapath: deductions never exceed credit, so only the top needs clamping.
  always_comb begin
    add_w = NW'(coin_in) * NW'(UNIT_VALUE);
    sub_w = '0;
    if (take_price) begin
      sub_w = NW'(price);
    end else if (take_change) begin
      sub_w = NW'(CHANGE_UNIT);
    end
    next_w   = NW'(credit) - sub_w + add_w;
    sat      = (next_w > NW'(MAX_CREDIT));
    credit_n = sat ? CREDIT_WIDTH'(MAX_CREDIT) : next_w[CREDIT_WIDTH-1:0];
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      credit        <= '0;
      dispense      <= 1'b0;
      change_pulse  <= 1'b0;
      busy          <= 1'b0;
      deny          <= 1'b0;
      coin_overflow <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      credit        <= credit_n;
      dispense      <= (state_n == DISPENSE);
      change_pulse  <= (state_n == CHANGE_HI);
      busy          <= (state_n != IDLE);
      deny          <= deny_n;
      coin_overflow <= sat;
    end
  end

endmodule

// File: tb/tb_credit_manager.sv
// tb/tb_credit_manager.sv - directed self-checking bench for credit_manager
module tb_credit_manager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  coin_in = '0;
  logic        vend_req = 1'b0;
  logic [11:0] price = '0;
  logic        refund_req = 1'b0;
  logic [11:0] credit;
  logic        dispense, change_pulse, busy, deny, coin_overflow;

  int vectors = 0;
  int errors  = 0;

  credit_manager #(
    .COIN_WIDTH(6), .CREDIT_WIDTH(12), .MAX_CREDIT(4000), .UNIT_VALUE(10),
    .DISPENSE_CYCLES(4), .CHANGE_UNIT(50), .CHANGE_PULSE_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .vend_req(vend_req), .price(price),
    .refund_req(refund_req), .credit(credit), .dispense(dispense),
    .change_pulse(change_pulse), .busy(busy), .deny(deny), .coin_overflow(coin_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then feed coins (at most 50 pulses each) until credit equals units.
  task automatic load_credit(input int units);
    int rem;
    rem = units / 10;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while (rem > 0) begin
      coin_in = 6'((rem > 50) ? 50 : rem);
      rem     = rem - ((rem > 50) ? 50 : rem);
      tick();
    end
    coin_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (credit !== 12'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    vectors++; if (dispense !== 1'b0) begin errors++; $display("FAIL reset_dispense: got %b expected 0", dispense); end
    vectors++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL reset_change: got %b expected 0", change_pulse); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (deny !== 1'b0) begin errors++; $display("FAIL reset_deny: got %b expected 0", deny); end
    vectors++; if (coin_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", coin_overflow); end
  endtask

  task automatic test_coin_add();
    coin_in = 6'd5;
    tick();
    coin_in = '0;
    vectors++; if (credit !== 12'd50) begin errors++; $display("FAIL coin_credit: got %0d expected 50", credit); end
    vectors++; if ({busy, dispense, change_pulse, deny, coin_overflow} !== 5'b0) begin
      errors++; $display("FAIL coin_side_effects: got %b expected 00000", {busy, dispense, change_pulse, deny, coin_overflow}); end
    coin_in = 6'd5;
    tick();
    coin_in = '0;
    vectors++; if (credit !== 12'd100) begin errors++; $display("FAIL coin_credit2: got %0d expected 100", credit); end
  endtask

  task automatic test_deny();
    load_credit(100);
    vend_req = 1'b1; price = 12'd120;
    tick();
    vend_req = 1'b0;
    vectors++; if (deny !== 1'b1) begin errors++; $display("FAIL deny_pulse: got %b expected 1", deny); end
    vectors++; if (credit !== 12'd100) begin errors++; $display("FAIL deny_credit: got %0d expected 100", credit); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL deny_busy: got %b expected 0", busy); end
    tick();
    vectors++; if (deny !== 1'b0) begin errors++; $display("FAIL deny_width: got %b expected 0", deny); end
  endtask

  task automatic test_vend_change();
    load_credit(200);
    vend_req = 1'b1; price = 12'd120;
    tick();
    vend_req = 1'b0;
    vectors++; if (credit !== 12'd80) begin errors++; $display("FAIL vend_credit: got %0d expected 80", credit); end
    vectors++; if (dispense !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL vend_start: got %b%b expected 11", dispense, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (dispense !== 1'b1) begin errors++; $display("FAIL vend_hold%0d: got %b expected 1", i, dispense); end
    end
    tick();
    vectors++; if (dispense !== 1'b0 || change_pulse !== 1'b1) begin
      errors++; $display("FAIL vend_to_change: got disp %b chg %b expected 0 1", dispense, change_pulse); end
    tick();
    vectors++; if (change_pulse !== 1'b1 || credit !== 12'd80) begin
      errors++; $display("FAIL change_hi2: got chg %b credit %0d expected 1 80", change_pulse, credit); end
    tick();
    vectors++; if (change_pulse !== 1'b0 || credit !== 12'd30) begin
      errors++; $display("FAIL change_lo1: got chg %b credit %0d expected 0 30", change_pulse, credit); end
    tick();
    vectors++; if (change_pulse !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL change_lo2: got chg %b busy %b expected 0 1", change_pulse, busy); end
    tick();
    vectors++; if (busy !== 1'b0 || credit !== 12'd30 || change_pulse !== 1'b0) begin
      errors++; $display("FAIL vend_done: got busy %b credit %0d chg %b expected 0 30 0", busy, credit, change_pulse); end
  endtask

  task automatic test_priority_and_edges();
    // Vend wins over refund even when the vend is denied.
    load_credit(100);
    vend_req = 1'b1; refund_req = 1'b1; price = 12'd120;
    tick();
    vend_req = 1'b0; refund_req = 1'b0;
    vectors++; if (deny !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL priority: got deny %b busy %b expected 1 0", deny, busy); end
    // Refund below one change unit is ignored.
    load_credit(40);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    vectors++; if (busy !== 1'b0 || credit !== 12'd40) begin errors++; $display("FAIL small_refund: got busy %b credit %0d expected 0 40", busy, credit); end
    // Zero price is always granted; residual under one unit means no change.
    vend_req = 1'b1; price = 12'd0;
    tick();
    vend_req = 1'b0;
    vectors++; if (dispense !== 1'b1 || credit !== 12'd40) begin errors++; $display("FAIL free_vend: got disp %b credit %0d expected 1 40", dispense, credit); end
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (busy !== 1'b0 || change_pulse !== 1'b0 || credit !== 12'd40) begin
      errors++; $display("FAIL free_vend_end: got busy %b chg %b credit %0d expected 0 0 40", busy, change_pulse, credit); end
  endtask

  task automatic test_overflow();
    load_credit(3990);
    vectors++; if (credit !== 12'd3990) begin errors++; $display("FAIL ovf_load: got %0d expected 3990", credit); end
    coin_in = 6'd1;
    tick();
    coin_in = '0;
    vectors++; if (credit !== 12'd4000 || coin_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_exact: got credit %0d ovf %b expected 4000 0", credit, coin_overflow); end
    load_credit(3990);
    coin_in = 6'd2;
    tick();
    coin_in = '0;
    vectors++; if (credit !== 12'd4000 || coin_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sat: got credit %0d ovf %b expected 4000 1", credit, coin_overflow); end
    tick();
    vectors++; if (credit !== 12'd4000 || coin_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_width: got credit %0d ovf %b expected 4000 0", credit, coin_overflow); end
  endtask

  task automatic test_payout_extend();
    int  pulses;
    bit  prev;
    load_credit(50);
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
    vectors++; if (change_pulse !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL refund_start: got chg %b busy %b expected 1 1", change_pulse, busy); end
    tick();
    tick();
    vectors++; if (credit !== 12'd0 || change_pulse !== 1'b0) begin errors++; $display("FAIL refund_paid: got credit %0d chg %b expected 0 0", credit, change_pulse); end
    coin_in = 6'd10;
    tick();
    coin_in = '0;
    vectors++; if (credit !== 12'd100 || change_pulse !== 1'b0) begin errors++; $display("FAIL extend_coin: got credit %0d chg %b expected 100 0", credit, change_pulse); end
    pulses = 0;
    prev   = change_pulse;
    for (int i = 0; i < 60 && busy; i++) begin
      tick();
      if (change_pulse && !prev) pulses++;
      prev = change_pulse;
    end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL extend_timeout: got busy %b expected 0", busy); end
    vectors++; if (pulses != 2) begin errors++; $display("FAIL extend_pulses: got %0d expected 2", pulses); end
    vectors++; if (credit !== 12'd0) begin errors++; $display("FAIL extend_credit: got %0d expected 0", credit); end
  endtask

  task automatic test_reset_mid_dispense();
    load_credit(200);
    vend_req = 1'b1; price = 12'd120;
    tick();
    vend_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (dispense !== 1'b0 || credit !== 12'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got disp %b credit %0d busy %b expected 0 0 0", dispense, credit, busy); end
  endtask

  task automatic test_idle_hold();
    int  pulses;
    bit  prev;
    load_credit(60);
    pulses = 0;
    prev   = 1'b0;
`ifdef CREDIT_TIMEOUT_EN
    for (int i = 0; i < 80; i++) begin
      tick();
      if (change_pulse && !prev) pulses++;
      prev = change_pulse;
      if (pulses > 0 && !busy) break;
    end
    vectors++; if (pulses != 1 || credit !== 12'd10 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_refund: got pulses %0d credit %0d busy %b expected 1 10 0", pulses, credit, busy); end
    for (int i = 0; i < 20; i++) tick();
    vectors++; if (credit !== 12'd10 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_residual: got credit %0d busy %b expected 10 0", credit, busy); end
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      if (change_pulse && !prev) pulses++;
      prev = change_pulse;
    end
    vectors++; if (pulses != 0 || credit !== 12'd60 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got pulses %0d credit %0d busy %b expected 0 60 0", pulses, credit, busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_coin_add();
    test_deny();
    test_vend_change();
    test_priority_and_edges();
    test_overflow();
    test_payout_extend();
    test_reset_mid_dispense();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
